multi_timer: RTL and testbench

Bus-mapped timer peripheral with N independent channels. It replaces the single-channel timer on the processor's shared 8-bit data/address bus. Each channel has a programmable period, periodic or one-shot mode, and an interrupt enable. Channel events are aggregated onto one interrupt line with a raise/ack handshake, and a write-1-to-clear status register identifies the source.

---
 rtl/multi_timer_pkg.sv | 20 ++
 rtl/multi_timer_channel.sv | 100 ++++++++++
 rtl/multi_timer.sv | 128 ++++++++++++
 tb/tb_multi_timer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_timer_pkg.sv
// Shared constants for the multi-channel bus timer: register offsets inside a
// channel window, CTRL bit positions and the per-channel address stride.
package multi_timer_pkg;

  // Byte offsets inside one channel's 4-byte register window
  localparam logic [1:0] OFF_PER_LO = 2'd0;
  localparam logic [1:0] OFF_PER_HI = 2'd1;
  localparam logic [1:0] OFF_CTRL   = 2'd2;
  localparam logic [1:0] OFF_COUNT  = 2'd3;

  // CTRL register bit positions; only these bits are stored
  localparam int CTRL_EN      = 0;
  localparam int CTRL_ONESHOT = 1;
  localparam int CTRL_IRQ_EN  = 2;
  localparam int CTRL_W       = 3;

  // Address distance between consecutive channel windows
  localparam int CH_STRIDE = 4;

endpackage

// File: rtl/multi_timer_channel.sv
// One timer channel: PERIOD/CTRL/COUNT registers, tick-driven counting and
// event generation. Read data for the addressed offset is produced
// combinationally; the top level registers it onto the bus.
module timer_channel
  import multi_timer_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic       clk,
  input  logic       srst_n,
  input  logic       tick,
  input  logic       wr_en,
  input  logic [1:0] off,
  input  logic [7:0] wr_data,
  output logic [7:0] rd_data,
  output logic       timer_event,
  output logic       irq_event
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0]  period_reg, period_next;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic [CTRL_W-1:0] ctrl_reg, ctrl_next;
  logic              en;
  logic              fire;

  assign en = ctrl_reg[CTRL_EN];

  // Event decision uses the state before any same-cycle bus write, so a CTRL
  // write never suppresses the pending flag of an event firing in that cycle.
  always_comb begin
    fire        = tick && en && (period_reg != '0) && (count_reg >= period_reg - ONE);
    timer_event = fire;
    irq_event   = fire && ctrl_reg[CTRL_IRQ_EN];
  end

  // Next-state: tick counting first, then bus writes override (write wins for EN)
  always_comb begin
    period_next = period_reg;
    ctrl_next   = ctrl_reg;
    count_next  = count_reg;

    if (tick && en) begin
      if (period_reg == '0) begin
        count_next = '0;
      end else if (fire) begin
        count_next = '0;
        if (ctrl_reg[CTRL_ONESHOT]) begin
          ctrl_next[CTRL_EN] = 1'b0;
        end
      end else begin
        count_next = count_reg + ONE;
      end
    end

    if (wr_en) begin
      case (off)
        OFF_PER_LO: period_next[7:0] = wr_data;
        OFF_PER_HI: period_next[CNT_W-1:8] = wr_data[CNT_W-9:0];
        OFF_CTRL: begin
          ctrl_next = wr_data[CTRL_W-1:0];
          if (!wr_data[CTRL_EN]) begin
            // Disabling freezes the count where it is
            count_next = count_reg;
          end else if (!en) begin
            // Enabling from stopped restarts the count
            count_next = '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Channel state registers
  always_ff @(posedge clk) begin
    if (!srst_n) begin
      period_reg <= '0;
      ctrl_reg   <= '0;
      count_reg  <= '0;
    end else begin
      period_reg <= period_next;
      ctrl_reg   <= ctrl_next;
      count_reg  <= count_next;
    end
  end

  // Read data for the addressed offset; unused upper bits read as zero
  always_comb begin
    rd_data = '0;
    case (off)
      OFF_PER_LO: rd_data = period_reg[7:0];
      OFF_PER_HI: rd_data[CNT_W-9:0] = period_reg[CNT_W-1:8];
      OFF_CTRL:   rd_data[CTRL_W-1:0] = ctrl_reg;
      OFF_COUNT:  rd_data = count_reg[7:0];
    endcase
  end

endmodule

// File: rtl/multi_timer.sv
// Bus-mapped N-channel timer. Holds the shared prescaler, address decode,
// registered read path with tristate driver, W1C status register and the
// interrupt raise/ack handshake.
module multi_timer
  import multi_timer_pkg::*;
#(
  parameter int         N_CH      = 4,
  parameter int         CNT_W     = 16,
  parameter int         PRESCALE  = 100000,
  parameter logic [7:0] BASE_ADDR = 8'hD0
) (
  input  logic       CLK,
  input  logic       RESET,
  inout  wire  [7:0] BUS_DATA,
  input  logic [7:0] BUS_ADDR,
  input  logic       BUS_WE,
  output logic       BUS_INTERRUPT_RAISE,
  input  logic       BUS_INTERRUPT_ACK
);

  localparam int              PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [7:0]      STATUS_OFF = 8'(CH_STRIDE * N_CH);

  logic [PW-1:0]   presc_reg, presc_next;
  logic            tick;

  logic [7:0]      addr_off;
  logic            in_range;
  logic            is_status;
  logic [2:0]      ch_sel;
  logic [1:0]      reg_off;

  logic [N_CH-1:0] ch_wr;
  logic [N_CH-1:0] ch_event;
  logic [N_CH-1:0] ch_irq;
  logic [7:0]      ch_rd [N_CH];

  logic [N_CH-1:0] status_reg, status_next;
  logic [N_CH-1:0] w1c_mask;
  logic            raise_reg, raise_next;

  logic [7:0]      rd_data_reg, rd_data_next;
  logic            oe_reg, oe_next;

  // Free-running prescaler; tick marks its last count
  always_comb begin
    tick       = (presc_reg == PRESC_LAST);
    presc_next = tick ? '0 : presc_reg + PW'(1);
  end

  // Address decode: channel windows followed by the status register
  assign addr_off  = BUS_ADDR - BASE_ADDR;
  assign in_range  = (BUS_ADDR >= BASE_ADDR) && (addr_off <= STATUS_OFF);
  assign is_status = in_range && (addr_off == STATUS_OFF);
  assign ch_sel    = addr_off[4:2];
  assign reg_off   = addr_off[1:0];

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    assign ch_wr[gi] = BUS_WE && in_range && !is_status && (ch_sel == 3'(gi));

    timer_channel #(
      .CNT_W (CNT_W)
    ) u_channel (
      .clk         (CLK),
      .srst_n      (RESET),
      .tick        (tick),
      .wr_en       (ch_wr[gi]),
      .off         (reg_off),
      .wr_data     (BUS_DATA),
      .rd_data     (ch_rd[gi]),
      .timer_event (ch_event[gi]),
      .irq_event   (ch_irq[gi])
    );
  end

  // Status W1C with events taking priority; raise set by IRQ events over ACK
  always_comb begin
    w1c_mask = '0;
    if (BUS_WE && is_status) begin
      w1c_mask = BUS_DATA[N_CH-1:0];
    end
    status_next = (status_reg & ~w1c_mask) | ch_event;

    raise_next = raise_reg;
    if (|ch_irq) begin
      raise_next = 1'b1;
    end else if (BUS_INTERRUPT_ACK) begin
      raise_next = 1'b0;
    end
  end

  // Read mux feeding the registered read-response stage
  always_comb begin
    rd_data_next = '0;
    oe_next      = !BUS_WE && in_range;
    if (is_status) begin
      rd_data_next[N_CH-1:0] = status_reg;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (ch_sel == 3'(i)) begin
          rd_data_next = ch_rd[i];
        end
      end
    end
  end

  // Top-level state: prescaler, status, raise and read response
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      presc_reg   <= '0;
      status_reg  <= '0;
      raise_reg   <= 1'b0;
      rd_data_reg <= '0;
      oe_reg      <= 1'b0;
    end else begin
      presc_reg   <= presc_next;
      status_reg  <= status_next;
      raise_reg   <= raise_next;
      rd_data_reg <= rd_data_next;
      oe_reg      <= oe_next;
    end
  end

  assign BUS_DATA            = oe_reg ? rd_data_reg : 8'hzz;
  assign BUS_INTERRUPT_RAISE = raise_reg;

endmodule

// File: tb/tb_multi_timer.sv
// Directed bench for multi_timer (PRESCALE=4, N_CH=4, BASE_ADDR=D0).
// The bus carries pull-ups, so a released bus reads back as 8'hFF.
module tb_multi_timer;

  localparam logic [7:0] IDLE = 8'h00;
  localparam logic [7:0] HIZ  = 8'hFF;

  logic       clk;
  logic       rst_n;
  logic [7:0] bus_addr;
  logic       bus_we;
  logic       ack;
  logic       raise;
  logic [7:0] tb_drv;
  logic       tb_oe;
  wire  [7:0] bus_data;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int presc_m  = 0;

  assign bus_data = tb_oe ? tb_drv : 8'hzz;

  for (genvar gi = 0; gi < 8; gi++) begin : g_pull
    pullup (bus_data[gi]);
  end

  multi_timer #(
    .N_CH      (4),
    .CNT_W     (16),
    .PRESCALE  (4),
    .BASE_ADDR (8'hD0)
  ) dut (
    .CLK                 (clk),
    .RESET               (rst_n),
    .BUS_DATA            (bus_data),
    .BUS_ADDR            (bus_addr),
    .BUS_WE              (bus_we),
    .BUS_INTERRUPT_RAISE (raise),
    .BUS_INTERRUPT_ACK   (ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter and reference prescaler phase (0..3, tick at 3)
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) presc_m <= 0;
    else        presc_m <= (presc_m == 3) ? 0 : presc_m + 1;
  end

  typedef struct {
    logic [7:0] addr;
    logic       we;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [19];

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end else begin
      $display("ok   %s: %b", name, act);
    end
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    bus_addr = a; bus_we = 1'b1; tb_drv = d; tb_oe = 1'b1;
    @(negedge clk);
    bus_we = 1'b0; tb_oe = 1'b0; bus_addr = IDLE;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
    @(negedge clk);
    bus_addr = a; bus_we = 1'b0;
    @(negedge clk);
    d = bus_data; bus_addr = IDLE;
  endtask

  task automatic ack_pulse();
    @(negedge clk); ack = 1'b1;
    @(negedge clk); ack = 1'b0;
  endtask

  task automatic wait_raise(input string name, output int at);
    at = -1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (raise) begin
        at = cyc;
        break;
      end
    end
    checks++;
    if (at < 0) begin
      failures++;
      $display("FAIL %s: raise got 0 expected 1 within 200 cycles", name);
    end else begin
      $display("ok   %s: raise at cycle %0d", name, at);
    end
  endtask

  // Ack until RAISE is low, then stop on the negedge where it rises again
  task automatic sync_event(input string name, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 4 && !ok; t++) begin
      ack_pulse();
      if (!raise) begin
        for (int n = 0; n < 8; n++) begin
          @(negedge clk);
          if (raise) begin
            ok = 1'b1;
            break;
          end
        end
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: raise edge got none expected one", name);
    end
  endtask

  initial begin
    logic [7:0] rd;
    int t1, t2;
    bit ok;

    rst_n = 1'b0; bus_addr = IDLE; bus_we = 1'b0; ack = 1'b0; tb_drv = 8'h00; tb_oe = 1'b0;

    vecs[0]  = '{8'hD0, 1'b0, 8'h00, 8'h00};
    vecs[1]  = '{8'hD2, 1'b0, 8'h00, 8'h00};
    vecs[2]  = '{8'hE0, 1'b0, 8'h00, 8'h00};
    vecs[3]  = '{8'hD0, 1'b1, 8'h34, 8'h00};
    vecs[4]  = '{8'hD1, 1'b1, 8'h12, 8'h00};
    vecs[5]  = '{8'hD0, 1'b0, 8'h00, 8'h34};
    vecs[6]  = '{8'hD1, 1'b0, 8'h00, 8'h12};
    vecs[7]  = '{8'hD3, 1'b1, 8'hFF, 8'h00};
    vecs[8]  = '{8'hD3, 1'b0, 8'h00, 8'h00};
    vecs[9]  = '{8'hD6, 1'b1, 8'hF8, 8'h00};
    vecs[10] = '{8'hD6, 1'b0, 8'h00, 8'h00};
    vecs[11] = '{8'hDD, 1'b1, 8'h5A, 8'h00};
    vecs[12] = '{8'hDD, 1'b0, 8'h00, 8'h5A};
    vecs[13] = '{8'hC0, 1'b0, 8'h00, HIZ};
    vecs[14] = '{8'hE1, 1'b0, 8'h00, HIZ};
    vecs[15] = '{8'hEF, 1'b0, 8'h00, HIZ};
    vecs[16] = '{8'hD0, 1'b1, 8'h00, 8'h00};
    vecs[17] = '{8'hD1, 1'b1, 8'h00, 8'h00};
    vecs[18] = '{8'hDD, 1'b1, 8'h00, 8'h00};

    repeat (3) @(negedge clk);
    check1("reset_raise", raise, 1'b0);
    check8("reset_bus_hiz", bus_data, HIZ);
    rst_n = 1'b1;

    // Register access table
    for (int i = 0; i < 19; i++) begin
      if (vecs[i].we) begin
        bus_write(vecs[i].addr, vecs[i].data);
      end else begin
        bus_read(vecs[i].addr, rd);
        check8($sformatf("vec%0d_rd_%h", i, vecs[i].addr), rd, vecs[i].exp);
      end
    end

    // 1. Periodic channel 0, period 3 ticks = 12 clocks
    bus_write(8'hD0, 8'h03);
    bus_write(8'hD2, 8'h05);
    wait_raise("periodic_first", t1);
    bus_read(8'hE0, rd);
    check8("periodic_status", rd, 8'h01);
    ack_pulse();
    check1("periodic_ack_clears", raise, 1'b0);
    bus_write(8'hE0, 8'h01);
    bus_read(8'hE0, rd);
    check8("periodic_w1c", rd, 8'h00);
    wait_raise("periodic_second", t2);
    checks++;
    if (t2 - t1 != 12) begin
      failures++;
      $display("FAIL periodic_interval: got %0d expected 12", t2 - t1);
    end else begin
      $display("ok   periodic_interval: %0d", t2 - t1);
    end
    bus_write(8'hD2, 8'h00);
    bus_write(8'hE0, 8'h01);
    ack_pulse();
    bus_read(8'hE0, rd);
    check8("periodic_cleanup_status", rd, 8'h00);

    // 2. One-shot channel 1
    bus_write(8'hD4, 8'h02);
    bus_write(8'hD6, 8'h07);
    wait_raise("oneshot_event", t1);
    bus_read(8'hD6, rd);
    check8("oneshot_ctrl", rd, 8'h06);
    bus_read(8'hD7, rd);
    check8("oneshot_count", rd, 8'h00);
    bus_read(8'hE0, rd);
    check8("oneshot_status", rd, 8'h02);
    bus_write(8'hE0, 8'h02);
    ack_pulse();
    repeat (40) @(negedge clk);
    bus_read(8'hE0, rd);
    check8("oneshot_no_more", rd, 8'h00);
    check1("oneshot_raise_low", raise, 1'b0);

    // 3. Simultaneous events on channel 2 (fires every tick)
    bus_write(8'hD8, 8'h01);
    bus_write(8'hDA, 8'h05);
    sync_event("sim_sync", ok);
    repeat (2) @(negedge clk);
    bus_write(8'hE0, 8'h04);          // held across the next event edge
    bus_read(8'hE0, rd);
    check8("sim_event_vs_w1c", rd, 8'h04);
    @(negedge clk); ack = 1'b1;       // cycle of the following event
    @(negedge clk); ack = 1'b0;
    check1("sim_event_vs_ack", raise, 1'b1);
    bus_write(8'hDA, 8'h00);
    bus_write(8'hE0, 8'h04);
    ack_pulse();
    bus_read(8'hE0, rd);
    check8("sim_cleanup_status", rd, 8'h00);
    check1("sim_cleanup_raise", raise, 1'b0);

    // 4. Masked channel 3
    bus_write(8'hDC, 8'h01);
    bus_write(8'hDE, 8'h01);
    repeat (20) @(negedge clk);
    check1("masked_raise", raise, 1'b0);
    bus_read(8'hE0, rd);
    check8("masked_status", rd, 8'h08);
    bus_write(8'hE0, 8'h08);
    repeat (6) @(negedge clk);
    bus_read(8'hE0, rd);
    check8("masked_status_again", rd, 8'h08);
    bus_write(8'hDC, 8'h00);
    bus_write(8'hE0, 8'h08);
    repeat (20) @(negedge clk);
    bus_read(8'hE0, rd);
    check8("period0_status", rd, 8'h00);
    bus_read(8'hDF, rd);
    check8("period0_count", rd, 8'h00);
    check1("period0_raise", raise, 1'b0);

    // 5. Bus read timing of COUNT; enable aligned to prescaler phase 0
    bus_write(8'hD0, 8'hC8);
    for (int n = 0; n < 8 && presc_m != 0; n++) @(negedge clk);
    bus_addr = 8'hD2; bus_we = 1'b1; tb_drv = 8'h01; tb_oe = 1'b1;
    @(negedge clk);
    bus_we = 1'b0; tb_oe = 1'b0; bus_addr = IDLE;
    repeat (21) @(negedge clk);
    bus_addr = 8'hD3;
    check8("read_addr_cycle_hiz", bus_data, HIZ);
    @(negedge clk);
    check8("read_count_value", bus_data, 8'h05);
    bus_addr = IDLE;
    @(negedge clk);
    check8("read_after_hiz", bus_data, HIZ);
    bus_addr = 8'hC0;
    @(negedge clk);
    bus_addr = IDLE;
    check8("read_c0_hiz", bus_data, HIZ);

    // 6. Reset while running with RAISE set
    bus_write(8'hD0, 8'h03);
    bus_write(8'hD2, 8'h05);
    wait_raise("reset_pre_raise", t1);
    rst_n = 1'b0;
    @(negedge clk);
    check1("reset_mid_raise", raise, 1'b0);
    check8("reset_mid_bus", bus_data, HIZ);
    rst_n = 1'b1;
    for (int a = 8'hD0; a <= 8'hE0; a++) begin
      bus_read(8'(a), rd);
      check8($sformatf("post_reset_%h", a[7:0]), rd, 8'h00);
    end
    repeat (20) @(negedge clk);
    check1("post_reset_raise", raise, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
